// File: rtl/tiny_pkg.sv
// Shared definitions for the tinyProcessor controller: opcodes, datapath
// select encodings and the controller state enum.
package tiny_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Shared with the logical unit.
  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_XOR = 2'b01;
  localparam logic [1:0] LOGIC_CMP = 2'b10;
  localparam logic [1:0] LOGIC_NOP = 2'b11;

  localparam logic [1:0] ALU_SEL_ADD   = 2'b00;
  localparam logic [1:0] ALU_SEL_SUB   = 2'b01;
  localparam logic [1:0] ALU_SEL_LOGIC = 2'b10;
  localparam logic [1:0] ALU_SEL_PASS  = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_TARGET = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/tiny_ctrl_decode.sv
// Combinational strobe decode: opcode + state -> datapath strobes.
// Strobes are live only in EXEC while the controller is active.
module tiny_ctrl_decode
  import tiny_pkg::*;
(
  input  state_e      state,
  input  logic [3:0]  opcode,
  input  logic        active,
  output logic        acc_we,
  output logic        reg_we,
  output logic [1:0]  alu_sel,
  output logic [1:0]  logic_op
);

  always_comb begin
    acc_we   = 1'b0;
    reg_we   = 1'b0;
    alu_sel  = ALU_SEL_ADD;
    logic_op = LOGIC_NOP;
    if (active && state == ST_EXEC) begin
      case (opcode)
        OP_ADD: begin
          acc_we  = 1'b1;
          alu_sel = ALU_SEL_ADD;
        end
        OP_SUB: begin
          acc_we  = 1'b1;
          alu_sel = ALU_SEL_SUB;
        end
        OP_AND: begin
          acc_we   = 1'b1;
          alu_sel  = ALU_SEL_LOGIC;
          logic_op = LOGIC_AND;
        end
        OP_XOR: begin
          acc_we   = 1'b1;
          alu_sel  = ALU_SEL_LOGIC;
          logic_op = LOGIC_XOR;
        end
        OP_CMP: logic_op = LOGIC_CMP;
        OP_LD: begin
          acc_we  = 1'b1;
          alu_sel = ALU_SEL_PASS;
        end
        OP_ST:   reg_we = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tiny_ctrl_fsm.sv
// Fetch/decode/execute controller for the 8-bit tinyProcessor: sequences
// instruction fetch, drives datapath strobes and resolves JMP/JC.
module tiny_ctrl_fsm
  import tiny_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  input  logic            cmp_flag,
  output logic [3:0]      reg_sel,
  output logic [1:0]      alu_sel,
  output logic [1:0]      logic_op,
  output logic            acc_we,
  output logic            reg_we,
  output logic            c_flag,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            c_q, c_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    if (en) begin
      case (state_q)
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          case (ir_q[7:4])
            OP_CMP: begin
              c_d     = cmp_flag;
              state_d = ST_FETCH;
            end
            OP_JMP, OP_JC: state_d = ST_TARGET;
            OP_HLT:        state_d = ST_HALT;
            default:       state_d = ST_FETCH;
          endcase
        end
        ST_TARGET: begin
          // Not-taken JC still has to step over its operand byte.
          if (ir_q[7:4] == OP_JMP || c_q)
            pc_d = PC_W'(imem_data);
          else
            pc_d = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Strobes are also masked by rst so an aborted instruction writes nothing.
  tiny_ctrl_decode u_decode (
    .state    (state_q),
    .opcode   (ir_q[7:4]),
    .active   (en & ~rst),
    .acc_we   (acc_we),
    .reg_we   (reg_we),
    .alu_sel  (alu_sel),
    .logic_op (logic_op)
  );

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign reg_sel   = ir_q[3:0];
  assign c_flag    = c_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_tiny_ctrl_fsm.sv
// Directed bench for tiny_ctrl_fsm: per-cycle expected outputs are queued
// as stimulus is applied and checked by a negedge scoreboard.
module tb_tiny_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst, en, cmp_flag;
  logic [7:0] imem_addr, imem_data, pc;
  logic [3:0] reg_sel;
  logic [1:0] alu_sel, logic_op;
  logic       acc_we, reg_we, c_flag, halted;

  logic [7:0] mem [256];

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  tiny_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cmp_flag  (cmp_flag),
    .reg_sel   (reg_sel),
    .alu_sel   (alu_sel),
    .logic_op  (logic_op),
    .acc_we    (acc_we),
    .reg_we    (reg_we),
    .c_flag    (c_flag),
    .pc        (pc),
    .halted    (halted)
  );

  logic [23:0] obs;
  assign obs = {imem_addr, pc, acc_we, reg_we, alu_sel, logic_op, c_flag, halted};

  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      tests++;
      assert (obs === cur.v) else begin
        fails++;
        $error("FAIL %s: observed {addr,pc,acc,reg,alu,lop,c,h}=%h expected %h",
               cur.tag, obs, cur.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Queue what this cycle must show, then advance one clock.
  task automatic step(input string tag, input logic [7:0] p, input logic a,
                      input logic r, input logic [1:0] alu, input logic [1:0] lop,
                      input logic c, input logic h);
    exp_t e;
    e.tag = tag;
    e.v   = {p, p, a, r, alu, lop, c, h};
    q.push_back(e);
    tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    step("reset", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    cmp_flag = 1'b0;
    clear_mem();

    // AND R1 ; XOR R2
    mem[8'h00] = 8'h31;
    mem[8'h01] = 8'h42;
    do_reset();
    step("p1_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("p1_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("p1_and", 8'h01, 1, 0, 2'b10, 2'b00, 0, 0);
    step("p1_c4", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("p1_c5", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("p1_xor", 8'h02, 1, 0, 2'b10, 2'b01, 0, 0);
    step("p1_c7", 8'h02, 0, 0, 2'b00, 2'b11, 0, 0);

    // CMP R3 with flag set ; JC 0x40 taken
    clear_mem();
    mem[8'h00] = 8'h53;
    mem[8'h01] = 8'h90;
    mem[8'h02] = 8'h40;
    cmp_flag   = 1'b1;
    do_reset();
    step("jc1_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc1_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc1_cmp", 8'h01, 0, 0, 2'b00, 2'b10, 0, 0);
    step("jc1_c4", 8'h01, 0, 0, 2'b00, 2'b11, 1, 0);
    step("jc1_c5", 8'h01, 0, 0, 2'b00, 2'b11, 1, 0);
    step("jc1_exec", 8'h02, 0, 0, 2'b00, 2'b11, 1, 0);
    step("jc1_target", 8'h02, 0, 0, 2'b00, 2'b11, 1, 0);
    step("jc1_taken", 8'h40, 0, 0, 2'b00, 2'b11, 1, 0);

    // Same program, flag clear: JC skips its operand
    cmp_flag = 1'b0;
    do_reset();
    step("jc0_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc0_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc0_cmp", 8'h01, 0, 0, 2'b00, 2'b10, 0, 0);
    step("jc0_c4", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc0_c5", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc0_exec", 8'h02, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc0_target", 8'h02, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jc0_skip", 8'h03, 0, 0, 2'b00, 2'b11, 0, 0);

    // JMP 0xFE ; at 0xFE: JMP 0x10 with operand at 0xFF
    clear_mem();
    mem[8'h00] = 8'h80;
    mem[8'h01] = 8'hFE;
    mem[8'hFE] = 8'h80;
    mem[8'hFF] = 8'h10;
    do_reset();
    step("jmp_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_c3", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_c4", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_fe_fetch", 8'hFE, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_fe_dec", 8'hFE, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_opnd_ff", 8'hFF, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_target", 8'hFF, 0, 0, 2'b00, 2'b11, 0, 0);
    step("jmp_to_10", 8'h10, 0, 0, 2'b00, 2'b11, 0, 0);

    // NOP at 0xFF wraps pc to 0x00
    clear_mem();
    mem[8'h00] = 8'h80;
    mem[8'h01] = 8'hFF;
    do_reset();
    step("wrap_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_c3", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_c4", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_fetch", 8'hFF, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_dec", 8'hFF, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_exec", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("wrap_fetch0", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);

    // ST R5 aborted by reset in EXEC, then run to completion
    clear_mem();
    mem[8'h00] = 8'h75;
    do_reset();
    step("st_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("st_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    rst = 1'b1;
    step("st_rst_exec", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    rst = 1'b0;
    step("st_after_rst", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("st_dec", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("st_exec", 8'h01, 0, 1, 2'b00, 2'b11, 0, 0);
    step("st_fetch", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);

    // AND R1 with en low for 5 cycles in DECODE and one cycle in EXEC
    clear_mem();
    mem[8'h00] = 8'h31;
    do_reset();
    step("en_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++)
      step($sformatf("en_hold%0d", i), 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    en = 1'b1;
    step("en_dec", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    en = 1'b0;
    step("en_exec_off", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    en = 1'b1;
    step("en_exec_on", 8'h01, 1, 0, 2'b10, 2'b00, 0, 0);
    step("en_fetch", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);

    // HLT: sticky until reset
    clear_mem();
    mem[8'h00] = 8'hF0;
    do_reset();
    step("hlt_c1", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("hlt_c2", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);
    step("hlt_exec", 8'h01, 0, 0, 2'b00, 2'b11, 0, 0);
    for (int i = 0; i < 20; i++)
      step($sformatf("halt%0d", i), 8'h01, 0, 0, 2'b00, 2'b11, 0, 1);
    rst = 1'b1;
    step("halt_rst_in", 8'h01, 0, 0, 2'b00, 2'b11, 0, 1);
    rst = 1'b0;
    step("halt_cleared", 8'h00, 0, 0, 2'b00, 2'b11, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
